plru_nway: RTL and testbench
============================

# plru_nway

Parametrised N-way tree pseudo-LRU replacement unit for the set-associative caches. It keeps one (NUM_WAYS-1)-bit tree per set and returns a registered victim way one cycle after a query. It also provides same-cycle update forwarding and a multi-cycle flush sequencer that clears all sets. It sits beside the tag/valid arrays and is driven by the cache controller FSM.

## Interface
- S_INDEX, 4, set-index width; NUM_SETS = 2**S_INDEX
- NUM_WAYS, 4, associativity; power of two, 2..16
- WAY_W, $clog2(NUM_WAYS), derived, do not override
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- query_valid  in  1  victim request this cycle
- query_set  in  S_INDEX  set for the query
- valid_i  in  NUM_WAYS  valid bits of query_set
- lock_i  in  NUM_WAYS  ways excluded from victimisation; present only with PLRU_LOCK_EN
- update_valid  in  1  record an access
- update_set  in  S_INDEX  set accessed
- update_way  in  WAY_W  way accessed (hit or fill)
- flush_req  in  1  pulse: clear every tree
- busy  out  1  flush in progress; queries/updates ignored
- victim_valid  out  1  victim_way valid; 1-cycle pulse
- victim_way  out  WAY_W  selected way
- victim_none  out  1  no way eligible; only with PLRU_LOCK_EN, else tied 0

## Operation
- Tree per set: node 0 is root; children of node i are 2i+1 and 2i+2; leaves map to ways 0..NUM_WAYS-1, left to right. Bit 0 means the victim is in the left subtree.
- Update: on every node along the path to update_way, set the bit to point away from that way.
- Victim priority:
  - lowest-index way with valid_i=0 (and not locked);
  - otherwise walk the tree from the root.
- Forwarding: when update_valid and query_valid fire in the same cycle with update_set == query_set, selection uses the post-update tree.
- FSM IDLE/FLUSH:
  - flush_req in IDLE goes to FLUSH with set counter 0.
  - FLUSH clears one set per cycle.
  - After set NUM_SETS-1 is cleared, return to IDLE.
- busy = (state == FLUSH).
- While busy: query_valid, update_valid and flush_req are ignored, and victim_valid stays 0.
- update_valid together with flush_req in IDLE: the update is written and the flush starts next cycle.
- Reset (any time, including mid-flush): all trees 0, state IDLE, counter 0, busy 0, victim_valid 0, victim_way 0, victim_none 0.

## Timing
- Query at edge N: victim_valid=1 and victim_way valid during cycle N+1; victim_way holds until the next accepted query.
- Update at edge N: visible to queries from cycle N+1, or the same cycle via forwarding.
- Flush: busy rises the cycle after flush_req and stays high exactly NUM_SETS cycles.
- Back-to-back queries: one per cycle, fully pipelined.

## Configuration
- PLRU_LOCK_EN defined:
  - lock_i port exists.
  - Locked ways are never selected.
  - Invalid-way scan skips locked ways.
  - During the tree walk, if the indicated subtree is fully locked, take the sibling.
  - If all ways are locked: victim_none=1 and victim_way=0 with victim_valid.
- PLRU_LOCK_EN undefined: no lock_i port, victim_none tied 0, plain tree walk.

## Structure
- plru_pkg holds:
  - the FSM state enum (PLRU_IDLE, PLRU_FLUSH);
  - tree-index helper functions (path bit update, leaf-to-node mapping).
- One sub-module, plru_nway_sel: combinational victim select from tree bits, valid_i and the lock mask. It is instantiated once on the query path.

## Test plan
Use NUM_WAYS=4 and S_INDEX=4 unless stated.
- Reset, then query set 3 with valid_i=4'b1111 -> next cycle victim_valid=1, victim_way=0.
- Update set 5 with way 0, then way 2; query set 5 with all valid -> victim_way=1.
- Query any set with valid_i=4'b1011 -> victim_way=2, regardless of tree state.
- After reset, update set 7 way 1 and query set 7 in the same cycle -> victim_way=2 (forwarding).
- Fill several sets, pulse flush_req -> busy high for 16 cycles, queries during busy give no victim_valid; afterwards all-valid queries return way 0. Assert rst mid-flush -> busy drops immediately.
- With PLRU_LOCK_EN:
  - lock_i=4'b0001 after reset -> victim_way=1;
  - lock_i=4'b1111 -> victim_none=1, victim_way=0.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for the plru_nway replacement unit.
// Heap-ordered tree: node 0 is the root, children of node i are 2i+1 and 2i+2.
package plru_pkg;

    typedef enum logic [0:0] {
        PLRU_IDLE  = 1'b0,
        PLRU_FLUSH = 1'b1
    } plru_state_e;

    // Heap index of the leaf that stands for a given way.
    function automatic int leaf_node(input int num_ways, input int way);
        return num_ways - 1 + way;
    endfunction

    function automatic int parent_node(input int node);
        return (node - 1) / 2;
    endfunction

    // Parent bit value that points away from this child: left children (odd index) push it right.
    function automatic logic path_bit(input int node);
        return (node % 2) == 1;
    endfunction

endpackage

// File: rtl/plru_nway_if.sv
// Request/response bundle between the cache controller and plru_nway.
// lock_i only exists when PLRU_LOCK_EN is defined.
interface plru_nway_if #(
    parameter int S_INDEX  = 4,
    parameter int NUM_WAYS = 4
);
    import plru_pkg::*;

    localparam int WAY_W = $clog2(NUM_WAYS);

    // query_valid, update_valid and flush_req are single-cycle strobes; busy is the
    // inverse of ready, so a strobe is accepted only in a cycle where busy is 0.
    logic                  query_valid;
    logic [S_INDEX-1:0]    query_set;
    logic [NUM_WAYS-1:0]   valid_i;
`ifdef PLRU_LOCK_EN
    logic [NUM_WAYS-1:0]   lock_i;
`endif
    logic                  update_valid;
    logic [S_INDEX-1:0]    update_set;
    logic [WAY_W-1:0]      update_way;
    logic                  flush_req;
    logic                  busy;
    logic                  victim_valid;
    logic [WAY_W-1:0]      victim_way;
    logic                  victim_none;
    plru_state_e           state;

    modport master (
`ifdef PLRU_LOCK_EN
        output lock_i,
`endif
        output query_valid, query_set, valid_i,
        output update_valid, update_set, update_way, flush_req,
        input  busy, victim_valid, victim_way, victim_none, state
    );

    modport slave (
`ifdef PLRU_LOCK_EN
        input  lock_i,
`endif
        input  query_valid, query_set, valid_i,
        input  update_valid, update_set, update_way, flush_req,
        output busy, victim_valid, victim_way, victim_none, state
    );

endinterface

// File: rtl/plru_nway_sel.sv
// Combinational victim select: first invalid unlocked way, else a lock-aware tree walk.
module plru_nway_sel #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         tree,
    input  logic [NUM_WAYS-1:0]         valid,
    input  logic [NUM_WAYS-1:0]         lock,
    output logic [$clog2(NUM_WAYS)-1:0] way,
    output logic                        none
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int NODES = NUM_WAYS - 1;

    always_comb begin
        logic [2*NUM_WAYS-2:0] elig;
        logic                  found;
        logic                  go;
        int                    node;

        // elig[n] is set when the subtree under heap node n holds at least one unlocked way
        elig = '0;
        for (int w = 0; w < NUM_WAYS; w++) elig[NODES + w] = ~lock[w];
        for (int n = NODES - 1; n >= 0; n--) elig[n] = elig[2*n + 1] | elig[2*n + 2];

        way   = '0;
        none  = ~elig[0];
        found = 1'b0;
        go    = 1'b0;
        node  = 0;

        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !valid[w] && !lock[w]) begin
                way   = WAY_W'(w);
                found = 1'b1;
            end
        end

        if (!found && elig[0]) begin
            for (int l = 0; l < WAY_W; l++) begin
                go = tree[node];
                if (!go && !elig[2*node + 1])
                    go = 1'b1;
                else if (go && !elig[2*node + 2])
                    go = 1'b0;
                node = 2*node + 1 + int'(go);
            end
            way = WAY_W'(node - NODES);
        end
    end

endmodule

// File: rtl/plru_nway.sv
// N-way tree pseudo-LRU with registered victim, same-set update forwarding and a flush sequencer.
// Define PLRU_LOCK_EN to add per-way lock masking (lock_i, victim_none).
module plru_nway
    import plru_pkg::*;
#(
    parameter int S_INDEX  = 4,
    parameter int NUM_WAYS = 4
) (
    input logic         clk,
    input logic         rst,
    plru_nway_if.slave  bus
);
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int NODES    = NUM_WAYS - 1;
    localparam int NUM_SETS = 2 ** S_INDEX;

    plru_state_e        state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;
    logic [NODES-1:0]   trees [NUM_SETS];
    logic [NODES-1:0]   query_tree;
    logic [NUM_WAYS-1:0] lock_mask;
    logic [WAY_W-1:0]   sel_way;
    logic               sel_none;
    logic               busy;
    logic               victim_valid_q;
    logic [WAY_W-1:0]   victim_way_q;
    logic               victim_none_q;

    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t, input logic [WAY_W-1:0] way);
        logic [NODES-1:0] r;
        int node;
        int p;
        r    = t;
        node = leaf_node(NUM_WAYS, int'(way));
        for (int l = 0; l < WAY_W; l++) begin
            p    = parent_node(node);
            r[p] = path_bit(node);
            node = p;
        end
        return r;
    endfunction

    assign busy = (state_q == PLRU_FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PLRU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PLRU_IDLE: begin
                if (bus.flush_req) begin
                    state_d = PLRU_FLUSH;
                    cnt_d   = '0;
                end
            end
            PLRU_FLUSH: begin
                cnt_d = cnt_q + S_INDEX'(1);
                if (cnt_q == S_INDEX'(NUM_SETS - 1)) begin
                    state_d = PLRU_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PLRU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) trees[s] <= '0;
        end else if (busy) begin
            trees[cnt_q] <= '0;
        end else if (bus.update_valid) begin
            trees[bus.update_set] <= touch(trees[bus.update_set], bus.update_way);
        end
    end

    // A same-cycle update to the queried set is folded in before selection.
    always_comb begin
        query_tree = trees[bus.query_set];
        if (bus.update_valid && (bus.update_set == bus.query_set))
            query_tree = touch(query_tree, bus.update_way);
    end

`ifdef PLRU_LOCK_EN
    assign lock_mask = bus.lock_i;
`else
    assign lock_mask = '0;
`endif

    plru_nway_sel #(.NUM_WAYS(NUM_WAYS)) u_sel (
        .tree  (query_tree),
        .valid (bus.valid_i),
        .lock  (lock_mask),
        .way   (sel_way),
        .none  (sel_none)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            victim_none_q  <= 1'b0;
        end else if (!busy && bus.query_valid) begin
            victim_valid_q <= 1'b1;
            victim_way_q   <= sel_way;
            victim_none_q  <= sel_none;
        end else begin
            victim_valid_q <= 1'b0;
        end
    end

    assign bus.busy         = busy;
    assign bus.state        = state_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;
    // Without locking the mask is all-zero, so sel_none and this register stay 0.
    assign bus.victim_none  = victim_none_q;

endmodule

// File: tb/tb_plru_nway.sv
// Directed bench for plru_nway (4 ways, 16 sets); lock cases compile in with PLRU_LOCK_EN.
module tb_plru_nway;
    import plru_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    plru_nway_if #(.S_INDEX(4), .NUM_WAYS(4)) bus ();

    plru_nway #(.S_INDEX(4), .NUM_WAYS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.query_valid  = 1'b0;
        bus.query_set    = '0;
        bus.valid_i      = 4'b1111;
        bus.update_valid = 1'b0;
        bus.update_set   = '0;
        bus.update_way   = '0;
        bus.flush_req    = 1'b0;
`ifdef PLRU_LOCK_EN
        bus.lock_i       = '0;
`endif
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic do_update(input logic [3:0] set, input logic [1:0] way);
        bus.update_valid = 1'b1;
        bus.update_set   = set;
        bus.update_way   = way;
        tick();
        bus.update_valid = 1'b0;
    endtask

    // Drives one query for a cycle; the result is observable right after return.
    task automatic do_query(input logic [3:0] set, input logic [3:0] valid);
        bus.query_valid = 1'b1;
        bus.query_set   = set;
        bus.valid_i     = valid;
        tick();
        bus.query_valid = 1'b0;
        bus.valid_i     = 4'b1111;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        n_cmp++;
        if (bus.victim_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid got=%0b exp=0", bus.victim_valid); end
        n_cmp++;
        if (bus.victim_way !== 2'd0) begin n_fail++; $display("FAIL reset_vway got=%0d exp=0", bus.victim_way); end
        n_cmp++;
        if (bus.victim_none !== 1'b0) begin n_fail++; $display("FAIL reset_vnone got=%0b exp=0", bus.victim_none); end
        n_cmp++;
        if (bus.state !== PLRU_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        do_query(4'd3, 4'b1111);
        n_cmp++;
        if (bus.victim_valid !== 1'b1) begin n_fail++; $display("FAIL first_query_vvalid got=%0b exp=1", bus.victim_valid); end
        n_cmp++;
        if (bus.victim_way !== 2'd0) begin n_fail++; $display("FAIL first_query_way got=%0d exp=0", bus.victim_way); end
        tick();
        n_cmp++;
        if (bus.victim_valid !== 1'b0) begin n_fail++; $display("FAIL vvalid_pulse got=%0b exp=0", bus.victim_valid); end
    endtask

    task automatic test_tree_walk();
        apply_reset();
        do_update(4'd5, 2'd0);
        do_update(4'd5, 2'd2);
        do_query(4'd5, 4'b1111);
        n_cmp++;
        if (bus.victim_way !== 2'd1) begin n_fail++; $display("FAIL walk_set5 got=%0d exp=1", bus.victim_way); end
        tick();
        tick();
        n_cmp++;
        if (bus.victim_way !== 2'd1) begin n_fail++; $display("FAIL way_hold got=%0d exp=1", bus.victim_way); end
        do_update(4'd1, 2'd0);
        do_query(4'd1, 4'b1111);
        n_cmp++;
        if (bus.victim_way !== 2'd2) begin n_fail++; $display("FAIL walk_set1 got=%0d exp=2", bus.victim_way); end
        n_cmp++;
        if (bus.victim_none !== 1'b0) begin n_fail++; $display("FAIL walk_none got=%0b exp=0", bus.victim_none); end
    endtask

    task automatic test_invalid_priority();
        do_query(4'd5, 4'b1011);
        n_cmp++;
        if (bus.victim_way !== 2'd2) begin n_fail++; $display("FAIL inval_set5 got=%0d exp=2", bus.victim_way); end
        do_query(4'd0, 4'b1011);
        n_cmp++;
        if (bus.victim_way !== 2'd2) begin n_fail++; $display("FAIL inval_set0 got=%0d exp=2", bus.victim_way); end
        do_query(4'd1, 4'b1110);
        n_cmp++;
        if (bus.victim_way !== 2'd0) begin n_fail++; $display("FAIL inval_set1 got=%0d exp=0", bus.victim_way); end
        do_query(4'd1, 4'b0111);
        n_cmp++;
        if (bus.victim_way !== 2'd3) begin n_fail++; $display("FAIL inval_way3 got=%0d exp=3", bus.victim_way); end
    endtask

    task automatic test_forwarding();
        apply_reset();
        bus.update_valid = 1'b1;
        bus.update_set   = 4'd7;
        bus.update_way   = 2'd1;
        do_query(4'd7, 4'b1111);
        bus.update_valid = 1'b0;
        n_cmp++;
        if (bus.victim_way !== 2'd2) begin n_fail++; $display("FAIL fwd_same_set got=%0d exp=2", bus.victim_way); end
        bus.update_valid = 1'b1;
        bus.update_set   = 4'd8;
        bus.update_way   = 2'd0;
        do_query(4'd9, 4'b1111);
        bus.update_valid = 1'b0;
        n_cmp++;
        if (bus.victim_way !== 2'd0) begin n_fail++; $display("FAIL fwd_other_set got=%0d exp=0", bus.victim_way); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_update(4'd1, 2'd0);
        do_update(4'd2, 2'd2);
        do_update(4'd3, 2'd0);
        do_update(4'd3, 2'd2);
        bus.query_valid = 1'b1;
        bus.query_set   = 4'd1;
        tick();
        bus.query_set   = 4'd2;
        n_cmp++;
        if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'd2) begin
            n_fail++; $display("FAIL b2b_0 got=%0b/%0d exp=1/2", bus.victim_valid, bus.victim_way);
        end
        tick();
        bus.query_set   = 4'd3;
        n_cmp++;
        if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'd0) begin
            n_fail++; $display("FAIL b2b_1 got=%0b/%0d exp=1/0", bus.victim_valid, bus.victim_way);
        end
        tick();
        bus.query_set   = 4'd1;
        n_cmp++;
        if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'd1) begin
            n_fail++; $display("FAIL b2b_2 got=%0b/%0d exp=1/1", bus.victim_valid, bus.victim_way);
        end
        tick();
        bus.query_valid = 1'b0;
        n_cmp++;
        if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'd2) begin
            n_fail++; $display("FAIL b2b_3 got=%0b/%0d exp=1/2", bus.victim_valid, bus.victim_way);
        end
    endtask

    task automatic test_flush();
        int busy_cycles;
        apply_reset();
        do_update(4'd5, 2'd0);
        do_update(4'd9, 2'd0);
        do_update(4'd15, 2'd3);
        do_query(4'd9, 4'b1111);
        n_cmp++;
        if (bus.victim_way !== 2'd2) begin n_fail++; $display("FAIL preflush_set9 got=%0d exp=2", bus.victim_way); end
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req    = 1'b0;
        bus.query_valid  = 1'b1;
        bus.query_set    = 4'd9;
        bus.update_valid = 1'b1;
        bus.update_set   = 4'd9;
        bus.update_way   = 2'd0;
        busy_cycles = 0;
        for (int i = 0; i < 20 && bus.busy === 1'b1; i++) begin
            busy_cycles++;
            n_cmp++;
            if (bus.victim_valid !== 1'b0) begin n_fail++; $display("FAIL busy_vvalid cyc=%0d got=%0b exp=0", i, bus.victim_valid); end
            tick();
        end
        n_cmp++;
        if (busy_cycles != 16) begin n_fail++; $display("FAIL busy_len got=%0d exp=16", busy_cycles); end
        n_cmp++;
        if (bus.victim_valid !== 1'b0) begin n_fail++; $display("FAIL flush_last_vvalid got=%0b exp=0", bus.victim_valid); end
        bus.query_valid  = 1'b0;
        bus.update_valid = 1'b0;
        do_query(4'd5, 4'b1111);
        n_cmp++;
        if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'd0) begin
            n_fail++; $display("FAIL postflush_set5 got=%0b/%0d exp=1/0", bus.victim_valid, bus.victim_way);
        end
        do_query(4'd9, 4'b1111);
        n_cmp++;
        if (bus.victim_way !== 2'd0) begin n_fail++; $display("FAIL postflush_set9 got=%0d exp=0", bus.victim_way); end
        do_query(4'd15, 4'b1111);
        n_cmp++;
        if (bus.victim_way !== 2'd0) begin n_fail++; $display("FAIL postflush_set15 got=%0d exp=0", bus.victim_way); end
    endtask

    task automatic test_reset_mid_flush();
        do_update(4'd4, 2'd0);
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midflush_busy got=%0b exp=1", bus.busy); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_drops_busy got=%0b exp=0", bus.busy); end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got=%0b exp=0", bus.busy); end
        do_update(4'd4, 2'd0);
        do_query(4'd4, 4'b1111);
        n_cmp++;
        if (bus.victim_valid !== 1'b1 || bus.victim_way !== 2'd2) begin
            n_fail++; $display("FAIL post_rst_query got=%0b/%0d exp=1/2", bus.victim_valid, bus.victim_way);
        end
    endtask

`ifdef PLRU_LOCK_EN
    task automatic test_lock();
        apply_reset();
        bus.lock_i = 4'b0001;
        do_query(4'd0, 4'b1111);
        n_cmp++;
        if (bus.victim_way !== 2'd1 || bus.victim_none !== 1'b0) begin
            n_fail++; $display("FAIL lock_0001 got=%0d/%0b exp=1/0", bus.victim_way, bus.victim_none);
        end
        bus.lock_i = 4'b0011;
        do_query(4'd0, 4'b1111);
        n_cmp++;
        if (bus.victim_way !== 2'd2) begin n_fail++; $display("FAIL lock_0011 got=%0d exp=2", bus.victim_way); end
        bus.lock_i = 4'b0001;
        do_query(4'd0, 4'b1100);
        n_cmp++;
        if (bus.victim_way !== 2'd1) begin n_fail++; $display("FAIL lock_inval_skip got=%0d exp=1", bus.victim_way); end
        bus.lock_i = 4'b1111;
        do_query(4'd0, 4'b1111);
        n_cmp++;
        if (bus.victim_valid !== 1'b1 || bus.victim_none !== 1'b1 || bus.victim_way !== 2'd0) begin
            n_fail++; $display("FAIL lock_all got=%0b/%0b/%0d exp=1/1/0", bus.victim_valid, bus.victim_none, bus.victim_way);
        end
        bus.lock_i = 4'b0000;
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle_inputs();
        test_reset();
        test_tree_walk();
        test_invalid_priority();
        test_forwarding();
        test_back_to_back();
        test_flush();
        test_reset_mid_flush();
`ifdef PLRU_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
